// File: rtl/aio20_spi_master.sv
// SPI initiator for one AIO20 analog I/O slot: CNVT strobe, wait for INT, one mode-0 frame.
// All pin outputs are registered; INT is synchronised and only its fresh rising edge counts.
module aio20_spi_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned CNVT_CYCLES = 8,
    parameter int unsigned INT_TIMEOUT = 1024
) (
    input  logic                  AIO20_CLK,
    input  logic                  AIO20_RST_N,
    input  logic                  AIO20_START_IN,
    input  logic [FRAME_BITS-1:0] AIO20_TX_DATA_IN,
    output logic                  AIO20_BUSY_OUT,
    output logic                  AIO20_DONE_OUT,
    output logic                  AIO20_TIMEOUT_OUT,
    output logic [FRAME_BITS-1:0] AIO20_RX_DATA_OUT,
    output logic                  AIO20_CNVT_OUT,
    input  logic                  AIO20_SPI_INT_IN,
    output logic                  AIO20_SPI_NSS_OUT,
    output logic                  AIO20_SPI_CLK_OUT,
    output logic                  AIO20_SPI_MOSI_OUT,
    input  logic                  AIO20_SPI_MISO_IN
);

    localparam int unsigned CntMax0 = (CNVT_CYCLES > INT_TIMEOUT) ? CNVT_CYCLES : INT_TIMEOUT;
    localparam int unsigned CntMax  = (CLK_DIV > CntMax0) ? CLK_DIV : CntMax0;
    localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned BitW    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CntW-1:0] CntCnvtLast    = CntW'(CNVT_CYCLES - 1);
    localparam logic [CntW-1:0] CntTimeoutLast = CntW'(INT_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntDivLast     = CntW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast        = BitW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCnvt,
        StWaitInt,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  cnvt_q, cnvt_d;
    logic                  nss_q, nss_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  edge_seen_q, edge_seen_d;
    logic                  int_meta_q, int_sync_q, int_dly_q;
    logic                  int_rise;

    assign int_rise = int_sync_q & ~int_dly_q;

    always_ff @(posedge AIO20_CLK or negedge AIO20_RST_N) begin
        if (!AIO20_RST_N) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            int_dly_q  <= 1'b0;
        end else begin
            int_meta_q <= AIO20_SPI_INT_IN;
            int_sync_q <= int_meta_q;
            int_dly_q  <= int_sync_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        cnvt_d      = cnvt_q;
        nss_d       = nss_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        edge_seen_d = edge_seen_q;

        unique case (state_q)
            StIdle: begin
                if (AIO20_START_IN) begin
                    state_d     = StCnvt;
                    busy_d      = 1'b1;
                    cnvt_d      = 1'b1;
                    tx_sh_d     = AIO20_TX_DATA_IN;
                    cnt_d       = '0;
                    edge_seen_d = 1'b0;
                end
            end
            StCnvt: begin
                // The module may answer before CNVT ends; keep that edge for WAIT_INT.
                if (int_rise) begin
                    edge_seen_d = 1'b1;
                end
                if (cnt_q == CntCnvtLast) begin
                    cnvt_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StWaitInt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitInt: begin
                if (int_rise || edge_seen_q) begin
                    state_d     = StSetup;
                    nss_d       = 1'b0;
                    sclk_d      = 1'b0;
                    mosi_d      = tx_sh_q[FRAME_BITS-1];
                    cnt_d       = '0;
                    edge_seen_d = 1'b0;
                end else if (cnt_q == CntTimeoutLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == CntDivLast) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b1;
                    rx_sh_d   = {rx_sh_q[FRAME_BITS-2:0], AIO20_SPI_MISO_IN};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q != CntDivLast) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q != BitLast) begin
                            mosi_d  = tx_sh_q[FRAME_BITS-2];
                            tx_sh_d = tx_sh_q << 1;
                        end
                    end else if (bit_cnt_q == BitLast) begin
                        state_d   = StHold;
                        nss_d     = 1'b1;
                        mosi_d    = 1'b0;
                        rx_data_d = rx_sh_q;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        rx_sh_d   = {rx_sh_q[FRAME_BITS-2:0], AIO20_SPI_MISO_IN};
                    end
                end
            end
            StHold: begin
                if (cnt_q == CntDivLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge AIO20_CLK or negedge AIO20_RST_N) begin
        if (!AIO20_RST_N) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnvt_q      <= 1'b0;
            nss_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            edge_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cnvt_q      <= cnvt_d;
            nss_q       <= nss_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            edge_seen_q <= edge_seen_d;
        end
    end

    assign AIO20_BUSY_OUT     = busy_q;
    assign AIO20_DONE_OUT     = done_q;
    assign AIO20_TIMEOUT_OUT  = timeout_q;
    assign AIO20_RX_DATA_OUT  = rx_data_q;
    assign AIO20_CNVT_OUT     = cnvt_q;
    assign AIO20_SPI_NSS_OUT  = nss_q;
    assign AIO20_SPI_CLK_OUT  = sclk_q;
    assign AIO20_SPI_MOSI_OUT = mosi_q;

endmodule

// File: tb/tb_aio20_spi_master.sv
// Directed bench for aio20_spi_master: frame vector table plus timeout, stale-INT, busy-START,
// mid-frame reset and back-to-back sequences against a mode-0 slave model.
module tb_aio20_spi_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] tx_in;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] rx_data;
    logic        cnvt;
    logic        int_in;
    logic        nss;
    logic        sclk;
    logic        mosi;
    logic        miso;

    aio20_spi_master #(
        .CLK_DIV    (4),
        .FRAME_BITS (16),
        .CNVT_CYCLES(8),
        .INT_TIMEOUT(1024)
    ) dut (
        .AIO20_CLK         (clk),
        .AIO20_RST_N       (rst_n),
        .AIO20_START_IN    (start),
        .AIO20_TX_DATA_IN  (tx_in),
        .AIO20_BUSY_OUT    (busy),
        .AIO20_DONE_OUT    (done),
        .AIO20_TIMEOUT_OUT (timeout),
        .AIO20_RX_DATA_OUT (rx_data),
        .AIO20_CNVT_OUT    (cnvt),
        .AIO20_SPI_INT_IN  (int_in),
        .AIO20_SPI_NSS_OUT (nss),
        .AIO20_SPI_CLK_OUT (sclk),
        .AIO20_SPI_MOSI_OUT(mosi),
        .AIO20_SPI_MISO_IN (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave model and pin monitor, evaluated mid-cycle when DUT pins are stable.
    logic [15:0] slv_word = 16'h0000;
    logic [4:0]  idx = 5'd16;
    logic        nss_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [15:0] mosi_cap = 16'h0000;
    int          rises = 0;
    int          nss_low = 0;
    int          done_cnt = 0;

    assign miso = idx[4] ? 1'b0 : slv_word[4'd15 - idx[3:0]];

    always @(negedge clk) begin
        if (nss_prev && !nss) begin
            idx <= 5'd0;
        end else if (!nss && sclk_prev && !sclk && !idx[4]) begin
            idx <= idx + 5'd1;
        end
        if (!nss && !sclk_prev && sclk) begin
            mosi_cap <= {mosi_cap[14:0], mosi};
            rises    <= rises + 1;
        end
        if (!nss) nss_low <= nss_low + 1;
        if (done) done_cnt <= done_cnt + 1;
        nss_prev  <= nss;
        sclk_prev <= sclk;
    end

    typedef struct {
        logic [15:0] tx;
        logic [15:0] slv;
        int          dly;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] tx);
        @(negedge clk);
        start = 1'b1;
        tx_in = tx;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cnvt_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!cnvt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_timeout(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n++;
            if (timeout) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] tx, input logic [15:0] slv, input int dly,
                             output bit ok);
        bit ok1;
        bit ok2;
        slv_word = slv;
        pulse_start(tx);
        wait_cnvt_low(ok1);
        repeat (dly) @(negedge clk);
        int_in = 1'b1;
        wait_done(3000, ok2);
        int_in = 1'b0;
        ok = ok1 & ok2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        bit          ok2;
        int          n;
        int          r0;
        int          n0;
        int          d0;
        logic [15:0] rx0;

        vecs[0] = '{tx: 16'hA5C3, slv: 16'h3C5A, dly: 20};
        vecs[1] = '{tx: 16'hFFFF, slv: 16'h0000, dly: 0};
        vecs[2] = '{tx: 16'h0001, slv: 16'h8000, dly: 3};
        vecs[3] = '{tx: 16'h1234, slv: 16'hFEDC, dly: 50};

        rst_n  = 1'b0;
        start  = 1'b0;
        tx_in  = 16'h0000;
        int_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_nss", 32'(nss), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_cnvt", 32'(cnvt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Frame vector table.
        for (int i = 0; i < 4; i++) begin
            r0 = rises;
            n0 = nss_low;
            d0 = done_cnt;
            run_frame(vecs[i].tx, vecs[i].slv, vecs[i].dly, ok);
            chk("vec_done_seen", 32'(ok), 32'd1);
            chk("vec_rx", 32'(rx_data), 32'(vecs[i].slv));
            repeat (8) @(negedge clk);
            chk("vec_mosi", 32'(mosi_cap), 32'(vecs[i].tx));
            chk("vec_sclk_rises", 32'(rises - r0), 32'd16);
            chk("vec_nss_low", 32'(nss_low - n0), 32'd132);
            chk("vec_done_count", 32'(done_cnt - d0), 32'd1);
            chk("vec_busy_idle", 32'(busy), 32'd0);
        end

        // Timeout with INT tied low.
        rx0 = rx_data;
        n0  = nss_low;
        d0  = done_cnt;
        pulse_start(16'h0F0F);
        wait_cnvt_low(ok);
        chk("to_cnvt_fall", 32'(ok), 32'd1);
        wait_timeout(1100, ok, n);
        chk("to_seen", 32'(ok), 32'd1);
        chk("to_latency", 32'(n), 32'd1024);
        chk("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("to_pulse_width", 32'(timeout), 32'd0);
        chk("to_nss_quiet", 32'(nss_low - n0), 32'd0);
        chk("to_rx_held", 32'(rx_data), 32'(rx0));
        chk("to_no_done", 32'(done_cnt - d0), 32'd0);

        // Stale INT level never qualifies.
        int_in = 1'b1;
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        n0 = nss_low;
        pulse_start(16'h1111);
        wait_timeout(1200, ok, n);
        chk("stale_timeout", 32'(ok), 32'd1);
        chk("stale_no_done", 32'(done_cnt - d0), 32'd0);
        chk("stale_nss_quiet", 32'(nss_low - n0), 32'd0);
        int_in = 1'b0;
        repeat (5) @(negedge clk);

        // INT pulse during CNVT is remembered.
        slv_word = 16'hC3C3;
        pulse_start(16'h5A5A);
        repeat (2) @(negedge clk);
        int_in = 1'b1;
        @(negedge clk);
        int_in = 1'b0;
        wait_done(3000, ok);
        chk("early_int_done", 32'(ok), 32'd1);
        chk("early_int_rx", 32'(rx_data), 32'hC3C3);
        repeat (8) @(negedge clk);
        chk("early_int_mosi", 32'(mosi_cap), 32'h5A5A);

        // START held high through every busy state.
        d0 = done_cnt;
        r0 = rises;
        slv_word = 16'h1111;
        pulse_start(16'hBEEF);
        start = 1'b1;
        tx_in = 16'h0000;
        wait_cnvt_low(ok);
        repeat (5) @(negedge clk);
        int_in = 1'b1;
        wait_done(3000, ok2);
        start  = 1'b0;
        int_in = 1'b0;
        chk("busy_start_done", 32'(ok & ok2), 32'd1);
        chk("busy_start_rx", 32'(rx_data), 32'h1111);
        repeat (300) @(negedge clk);
        chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_start_mosi", 32'(mosi_cap), 32'hBEEF);
        chk("busy_start_rises", 32'(rises - r0), 32'd16);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        d0 = done_cnt;
        r0 = rises;
        slv_word = 16'h3C5A;
        pulse_start(16'hA5C3);
        wait_cnvt_low(ok);
        int_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rises - r0 >= 7) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        chk("rst_mid_pre_nss", 32'(nss), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_nss", 32'(nss), 32'd1);
        chk("rst_mid_sclk", 32'(sclk), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rx", 32'(rx_data), 32'd0);
        chk("rst_mid_mosi", 32'(mosi), 32'd0);
        int_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_rx_after", 32'(rx_data), 32'd0);
        run_frame(16'h1357, 16'h2468, 10, ok);
        chk("rst_mid_recover_done", 32'(ok), 32'd1);
        chk("rst_mid_recover_rx", 32'(rx_data), 32'h2468);
        repeat (8) @(negedge clk);
        chk("rst_mid_recover_mosi", 32'(mosi_cap), 32'h1357);

        // Back-to-back frames.
        d0 = done_cnt;
        run_frame(16'h0001, 16'h8001, 4, ok);
        chk("b2b_first_done", 32'(ok), 32'd1);
        chk("b2b_first_rx", 32'(rx_data), 32'h8001);
        chk("b2b_first_mosi", 32'(mosi_cap), 32'h0001);
        slv_word = 16'h7FFE;
        pulse_start(16'h8000);
        chk("b2b_accept", 32'(busy), 32'd1);
        chk("b2b_cnvt", 32'(cnvt), 32'd1);
        wait_cnvt_low(ok);
        repeat (2) @(negedge clk);
        int_in = 1'b1;
        wait_done(3000, ok2);
        int_in = 1'b0;
        chk("b2b_second_done", 32'(ok & ok2), 32'd1);
        chk("b2b_second_rx", 32'(rx_data), 32'h7FFE);
        repeat (8) @(negedge clk);
        chk("b2b_second_mosi", 32'(mosi_cap), 32'h8000);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
